alu_seq_driver: RTL and testbench
=================================

Name: alu_seq_driver

Overview:
Sequencing initiator for the 8-bit parametrizable ALU. It accepts operation commands over a valid/ready interface and drives the ALU's A, B and ALU_Sel inputs from registers. It captures Result/CarryOut/Zero and returns them over a valid/ready response interface. An optional repeat count re-issues the same operation with the previous result fed back as A, for example to build multi-bit shifts or repeated adds.

Parameters:
WIDTH, 8, operand/result width; must match the attached ALU.
CNT_W, 4, width of repeat-count field.

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
cmd_valid  in  1  command present
cmd_ready  out  1  command accepted when cmd_valid & cmd_ready
cmd_sel  in  3  ALU operation code (ALU encoding 000..111)
cmd_a  in  WIDTH  first operand
cmd_b  in  WIDTH  second operand
cmd_count  in  CNT_W  iterations; 0 treated as 1
alu_a  out  WIDTH  to ALU A
alu_b  out  WIDTH  to ALU B
alu_sel  out  3  to ALU ALU_Sel
alu_result  in  WIDTH  from ALU Result
alu_carry  in  1  from ALU CarryOut
alu_zero  in  1  from ALU Zero
rsp_valid  out  1  response present
rsp_ready  in  1  response consumed when rsp_valid & rsp_ready
rsp_result  out  WIDTH  final result
rsp_carry  out  1  carry flag
rsp_zero  out  1  zero flag of final result
busy  out  1  state != IDLE

Behaviour:
- Clock and reset: one clock (clk). Reset is asynchronous and active-low (rst_n).
- Reset values: state=IDLE; alu_a, alu_b, alu_sel, rsp_result = 0; rsp_carry=0, rsp_zero=0, rsp_valid=0, busy=0.
- cmd_ready is 1 only in IDLE. It is combinational from the state, not from cmd_valid.
- All outputs are registered except cmd_ready and busy, which decode state.
- FSM states: IDLE, EXEC, RESP.
- IDLE: on cmd_valid:
  - latch alu_a<=cmd_a, alu_b<=cmd_b, alu_sel<=cmd_sel;
  - remaining<=max(cmd_count,1);
  - go to EXEC.
- EXEC: the ALU is combinational; its outputs are sampled every EXEC cycle.
  - If remaining==1: rsp_result<=alu_result, rsp_zero<=alu_zero, rsp_carry<=alu_carry (see Optional Feature); go to RESP.
  - Else: alu_a<=alu_result; alu_b and alu_sel hold; remaining<=remaining-1; stay in EXEC.
- RESP: rsp_valid=1. rsp_result, rsp_carry and rsp_zero hold stable until the handshake. On rsp_ready go to IDLE; rsp_valid deasserts at the same edge.
- Latency: with accept at edge E0 and N iterations, rsp_valid rises at edge E_N. N=1 gives one cycle.
- Back-to-back commands: the earliest next accept is the cycle after the response handshake. There is no overlap.
- alu_a, alu_b and alu_sel hold their last values in IDLE and RESP; they are not cleared.
- Arithmetic: no width conversion. Flags are taken verbatim from the ALU, including the SUB borrow semantics of CarryOut.
- Max count: 2^CNT_W-1. The remaining counter never wraps: it is loaded ≥1 and decremented only while >1.
- Reset mid-operation (any state): immediate return to the reset values; the in-flight command and response are dropped. The first command after rst_n deasserts is accepted normally.
- cmd_* inputs are ignored outside IDLE.
- Changes to rsp_ready outside RESP have no effect.

Optional Feature:
Macro: ALU_SEQ_STICKY_CARRY_EN.
- Defined: rsp_carry is the OR of alu_carry over all N iterations. The accumulator clears on accept.
- Undefined: rsp_carry is alu_carry of the final iteration only.
- rsp_result and rsp_zero are identical in both builds.

Test Plan:
- ADD (000), a=8'h0F, b=8'h01, count=1 -> rsp_result=8'h10, carry=0, zero=0; rsp_valid one edge after accept.
- ADD, a=8'hFF, b=8'h01, count=1 -> rsp_result=8'h00, carry=1, zero=1.
- SHL (110), a=8'h01, count=3 -> alu_a sequence 01,02,04; rsp_result=8'h08; rsp_valid at 3rd edge after accept.
- SUB (001), a=8'h05, b=8'h05, count=0 -> treated as 1; rsp_result=8'h00, zero=1.
- ADD, a=8'hF0, b=8'h20, count=2 -> rsp_result=8'h30; rsp_carry=0 without the macro, 1 with ALU_SEQ_STICKY_CARRY_EN.
- Backpressure and reset:
  - Hold rsp_ready=0 for 5 cycles in RESP -> response stable, cmd_ready=0.
  - Then issue count=8 and pulse rst_n low mid-EXEC -> all outputs 0, cmd_ready=1, next command completes correctly.

Source files
------------

// File: rtl/alu_seq_driver.sv
`default_nettype none
// ============================================================================
// Module      : alu_seq_driver
// Description : Sequencing initiator for an 8-bit combinational ALU. Accepts
//               an operation over a valid/ready command port, drives the ALU
//               A/B/ALU_Sel inputs from registers, and returns the result and
//               flags over a valid/ready response port. A repeat count
//               re-issues the operation with the previous result fed back as A.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters  : WIDTH - operand/result width (must match the ALU)
//               CNT_W - width of the repeat-count field
// Ports       : clk, rst_n                      clock / async active-low reset
//               cmd_valid/ready/sel/a/b/count   command channel
//               alu_a, alu_b, alu_sel           registered ALU inputs
//               alu_result, alu_carry, alu_zero ALU outputs (sampled in EXEC)
//               rsp_valid/ready/result/carry/zero  response channel
//               busy                            FSM not idle
// Options     : ALU_SEQ_STICKY_CARRY_EN - when defined, rsp_carry is the OR
//               of the ALU carry over every iteration of the command;
//               otherwise it is the carry of the final iteration only.
// ============================================================================
module alu_seq_driver #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_sel,
  input  logic [WIDTH-1:0] cmd_a,
  input  logic [WIDTH-1:0] cmd_b,
  input  logic [CNT_W-1:0] cmd_count,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_sel,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_carry,
  input  logic             alu_zero,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_carry,
  output logic             rsp_zero,
  output logic             busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] c_one = CNT_W'(1);

  state_t           r_state,      w_state_nxt;
  logic [WIDTH-1:0] r_alu_a,      w_alu_a_nxt;
  logic [WIDTH-1:0] r_alu_b,      w_alu_b_nxt;
  logic [2:0]       r_alu_sel,    w_alu_sel_nxt;
  logic [CNT_W-1:0] r_remaining,  w_remaining_nxt;
  logic [WIDTH-1:0] r_rsp_result, w_rsp_result_nxt;
  logic             r_rsp_carry,  w_rsp_carry_nxt;
  logic             r_rsp_zero,   w_rsp_zero_nxt;
  logic             r_rsp_valid,  w_rsp_valid_nxt;
`ifdef ALU_SEQ_STICKY_CARRY_EN
  logic             r_carry_acc,  w_carry_acc_nxt;
`endif

  // Next-state and datapath decode; every target defaults to hold.
  always_comb begin
    w_state_nxt      = r_state;
    w_alu_a_nxt      = r_alu_a;
    w_alu_b_nxt      = r_alu_b;
    w_alu_sel_nxt    = r_alu_sel;
    w_remaining_nxt  = r_remaining;
    w_rsp_result_nxt = r_rsp_result;
    w_rsp_carry_nxt  = r_rsp_carry;
    w_rsp_zero_nxt   = r_rsp_zero;
    w_rsp_valid_nxt  = r_rsp_valid;
`ifdef ALU_SEQ_STICKY_CARRY_EN
    w_carry_acc_nxt  = r_carry_acc;
`endif
    case (r_state)
      S_IDLE: begin
        if (cmd_valid) begin
          w_alu_a_nxt     = cmd_a;
          w_alu_b_nxt     = cmd_b;
          w_alu_sel_nxt   = cmd_sel;
          // A zero count still performs one iteration.
          w_remaining_nxt = (cmd_count == '0) ? c_one : cmd_count;
`ifdef ALU_SEQ_STICKY_CARRY_EN
          w_carry_acc_nxt = 1'b0;
`endif
          w_state_nxt     = S_EXEC;
        end
      end
      S_EXEC: begin
        if (r_remaining == c_one) begin
          w_rsp_result_nxt = alu_result;
          w_rsp_zero_nxt   = alu_zero;
`ifdef ALU_SEQ_STICKY_CARRY_EN
          w_rsp_carry_nxt  = r_carry_acc | alu_carry;
`else
          w_rsp_carry_nxt  = alu_carry;
`endif
          w_rsp_valid_nxt  = 1'b1;
          w_state_nxt      = S_RESP;
        end else begin
          // Feed the result back as A; B and the opcode hold. The counter
          // only decrements while above one, so it can never wrap.
          w_alu_a_nxt     = alu_result;
          w_remaining_nxt = r_remaining - c_one;
`ifdef ALU_SEQ_STICKY_CARRY_EN
          w_carry_acc_nxt = r_carry_acc | alu_carry;
`endif
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          w_rsp_valid_nxt = 1'b0;
          w_state_nxt     = S_IDLE;
        end
      end
      default: begin
        w_rsp_valid_nxt = 1'b0;
        w_state_nxt     = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_alu_a      <= '0;
      r_alu_b      <= '0;
      r_alu_sel    <= '0;
      r_remaining  <= '0;
      r_rsp_result <= '0;
      r_rsp_carry  <= 1'b0;
      r_rsp_zero   <= 1'b0;
      r_rsp_valid  <= 1'b0;
`ifdef ALU_SEQ_STICKY_CARRY_EN
      r_carry_acc  <= 1'b0;
`endif
    end else begin
      r_state      <= w_state_nxt;
      r_alu_a      <= w_alu_a_nxt;
      r_alu_b      <= w_alu_b_nxt;
      r_alu_sel    <= w_alu_sel_nxt;
      r_remaining  <= w_remaining_nxt;
      r_rsp_result <= w_rsp_result_nxt;
      r_rsp_carry  <= w_rsp_carry_nxt;
      r_rsp_zero   <= w_rsp_zero_nxt;
      r_rsp_valid  <= w_rsp_valid_nxt;
`ifdef ALU_SEQ_STICKY_CARRY_EN
      r_carry_acc  <= w_carry_acc_nxt;
`endif
    end
  end

  assign cmd_ready  = (r_state == S_IDLE);
  assign busy       = (r_state != S_IDLE);
  assign alu_a      = r_alu_a;
  assign alu_b      = r_alu_b;
  assign alu_sel    = r_alu_sel;
  assign rsp_valid  = r_rsp_valid;
  assign rsp_result = r_rsp_result;
  assign rsp_carry  = r_rsp_carry;
  assign rsp_zero   = r_rsp_zero;

endmodule
`default_nettype wire

// File: tb/tb_alu_seq_driver.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_seq_driver
// Description : Self-checking bench for alu_seq_driver. Contains a behavioural
//               8-bit ALU, a vector table applied through a scoreboard queue,
//               and hand-written backpressure / feedback / reset sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_seq_driver;

  localparam int WIDTH = 8;
  localparam int CNT_W = 4;
`ifdef ALU_SEQ_STICKY_CARRY_EN
  localparam logic STICKY = 1'b1;
`else
  localparam logic STICKY = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [2:0]       cmd_sel = '0;
  logic [WIDTH-1:0] cmd_a = '0;
  logic [WIDTH-1:0] cmd_b = '0;
  logic [CNT_W-1:0] cmd_count = '0;
  logic [WIDTH-1:0] alu_a, alu_b;
  logic [2:0]       alu_sel;
  logic [WIDTH-1:0] alu_result;
  logic             alu_carry, alu_zero;
  logic             rsp_valid;
  logic             rsp_ready = 1'b0;
  logic [WIDTH-1:0] rsp_result;
  logic             rsp_carry, rsp_zero, busy;

  always #5 clk = ~clk;

  alu_seq_driver #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_sel(cmd_sel),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_count(cmd_count),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
    .alu_result(alu_result), .alu_carry(alu_carry), .alu_zero(alu_zero),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_carry(rsp_carry), .rsp_zero(rsp_zero), .busy(busy)
  );

  // Behavioural ALU: 000 ADD, 001 SUB (carry = borrow), 010 AND, 011 OR,
  // 100 XOR, 101 NOT A, 110 SHL (carry = bit out), 111 SHR (carry = bit out).
  always_comb begin
    logic [WIDTH:0] t;
    t = '0;
    case (alu_sel)
      3'd0: t = {1'b0, alu_a} + {1'b0, alu_b};
      3'd1: t = {(alu_a < alu_b), alu_a - alu_b};
      3'd2: t = {1'b0, alu_a & alu_b};
      3'd3: t = {1'b0, alu_a | alu_b};
      3'd4: t = {1'b0, alu_a ^ alu_b};
      3'd5: t = {1'b0, ~alu_a};
      3'd6: t = {alu_a[WIDTH-1], alu_a[WIDTH-2:0], 1'b0};
      default: t = {alu_a[0], 1'b0, alu_a[WIDTH-1:1]};
    endcase
    alu_result = t[WIDTH-1:0];
    alu_carry  = t[WIDTH];
    alu_zero   = (t[WIDTH-1:0] == '0);
  end

  typedef struct {
    logic [2:0]       sel;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] res;
    logic             c;
    logic             z;
    int               lat;
  } vec_t;

  vec_t vecs[14];
  vec_t sb[$];

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Issue one command, wait for its response (bounded), compare against the
  // scoreboard head, optionally stall rsp_ready for 'hold' cycles, then
  // complete the handshake.
  task automatic do_cmd(input vec_t v, input int hold);
    vec_t e;
    int   lat;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_sel = v.sel; cmd_a = v.a; cmd_b = v.b; cmd_count = v.cnt;
    chk("cmd_ready_idle", {31'd0, cmd_ready}, 32'd1);
    @(posedge clk);
    sb.push_back(v);
    #1;
    cmd_valid = 1'b0;
    cmd_a = WIDTH'($urandom); cmd_b = WIDTH'($urandom);
    chk("busy_exec", {31'd0, busy}, 32'd1);
    lat = 0;
    while (lat < 40 && !rsp_valid) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("rsp_valid_seen", {31'd0, rsp_valid}, 32'd1);
    if (rsp_valid && sb.size() > 0) begin
      e = sb.pop_front();
      chk("latency", lat, e.lat);
      chk("rsp_result", {24'd0, rsp_result}, {24'd0, e.res});
      chk("rsp_carry", {31'd0, rsp_carry}, {31'd0, e.c});
      chk("rsp_zero", {31'd0, rsp_zero}, {31'd0, e.z});
      for (int h = 0; h < hold; h++) begin
        @(posedge clk); #1;
        chk("hold_valid", {31'd0, rsp_valid}, 32'd1);
        chk("hold_result", {24'd0, rsp_result}, {24'd0, e.res});
        chk("hold_flags", {30'd0, rsp_carry, rsp_zero}, {30'd0, e.c, e.z});
        chk("hold_cmd_ready", {31'd0, cmd_ready}, 32'd0);
      end
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk("valid_drop", {31'd0, rsp_valid}, 32'd0);
    chk("idle_after", {30'd0, cmd_ready, busy}, 32'd2);
  endtask

  initial begin
    //           sel     a      b      cnt    res    c       z     lat
    vecs[0]  = '{3'd0, 8'h0F, 8'h01, 4'd1,  8'h10, 1'b0,   1'b0, 1};
    vecs[1]  = '{3'd0, 8'hFF, 8'h01, 4'd1,  8'h00, 1'b1,   1'b1, 1};
    vecs[2]  = '{3'd6, 8'h01, 8'h00, 4'd3,  8'h08, 1'b0,   1'b0, 3};
    vecs[3]  = '{3'd1, 8'h05, 8'h05, 4'd0,  8'h00, 1'b0,   1'b1, 1};
    vecs[4]  = '{3'd0, 8'hF0, 8'h20, 4'd2,  8'h30, STICKY, 1'b0, 2};
    vecs[5]  = '{3'd2, 8'hF0, 8'h3C, 4'd1,  8'h30, 1'b0,   1'b0, 1};
    vecs[6]  = '{3'd4, 8'hAA, 8'hAA, 4'd1,  8'h00, 1'b0,   1'b1, 1};
    vecs[7]  = '{3'd1, 8'h03, 8'h05, 4'd1,  8'hFE, 1'b1,   1'b0, 1};
    vecs[8]  = '{3'd0, 8'h00, 8'h01, 4'd15, 8'h0F, 1'b0,   1'b0, 15};
    vecs[9]  = '{3'd7, 8'h80, 8'h00, 4'd7,  8'h01, 1'b0,   1'b0, 7};
    vecs[10] = '{3'd3, 8'h00, 8'h00, 4'd1,  8'h00, 1'b0,   1'b1, 1};
    vecs[11] = '{3'd6, 8'h81, 8'h00, 4'd1,  8'h02, 1'b1,   1'b0, 1};
    vecs[12] = '{3'd5, 8'h0F, 8'h00, 4'd1,  8'hF0, 1'b0,   1'b0, 1};
    vecs[13] = '{3'd6, 8'h01, 8'h00, 4'd8,  8'h00, 1'b1,   1'b1, 8};

    // Reset state while rst_n is held low.
    #3;
    chk("rst_alu", {5'd0, alu_sel, alu_a, alu_b, 8'd0}, 32'd0);
    chk("rst_rsp", {22'd0, rsp_valid, rsp_carry, rsp_zero, rsp_result}, 32'd0);
    chk("rst_ready_busy", {30'd0, cmd_ready, busy}, 32'd2);
    @(negedge clk); rst_n = 1'b1;

    for (int i = 0; i < 14; i++) do_cmd(vecs[i], 0);

    // Feedback path: A must walk 01, 02, 04 and hold once in RESP.
    @(negedge clk);
    cmd_valid = 1'b1; cmd_sel = 3'd6; cmd_a = 8'h01; cmd_b = 8'h00; cmd_count = 4'd3;
    @(posedge clk); #1; cmd_valid = 1'b0;
    chk("shl_a0", {24'd0, alu_a}, 32'h01);
    @(posedge clk); #1;
    chk("shl_a1", {24'd0, alu_a}, 32'h02);
    @(posedge clk); #1;
    chk("shl_a2", {24'd0, alu_a}, 32'h04);
    chk("shl_not_yet", {31'd0, rsp_valid}, 32'd0);
    @(posedge clk); #1;
    chk("shl_rsp", {23'd0, rsp_valid, rsp_result}, {23'd0, 1'b1, 8'h08});
    chk("shl_a_hold", {24'd0, alu_a}, 32'h04);
    rsp_ready = 1'b1; @(posedge clk); #1; rsp_ready = 1'b0;

    // Backpressure: response stalled for 5 cycles.
    do_cmd(vecs[7], 5);

    // Reset pulse in the middle of an 8-iteration command.
    @(negedge clk);
    cmd_valid = 1'b1; cmd_sel = 3'd0; cmd_a = 8'h00; cmd_b = 8'h01; cmd_count = 4'd8;
    @(posedge clk); #1; cmd_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1; rsp_ready = 1'b1; rst_n = 1'b0;
    #1;
    chk("midrst_alu", {5'd0, alu_sel, alu_a, alu_b, 8'd0}, 32'd0);
    chk("midrst_rsp", {22'd0, rsp_valid, rsp_carry, rsp_zero, rsp_result}, 32'd0);
    chk("midrst_ready_busy", {30'd0, cmd_ready, busy}, 32'd2);
    rsp_ready = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    do_cmd(vecs[4], 0);

    chk("sb_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
